// File: rtl/sfu_conflict_serializer.sv
// ---------------------------------------------------------------------------
// sfu_conflict_serializer
//
// Purpose:
//   Sits after sfu_check. A pair that targets two different SFUs goes out on
//   both lanes in one beat. A pair flagged as targeting the same SFU is split
//   into two beats: lane 0 goes first, then the lane-1 sample goes from a hold
//   register. Input is stalled while that second beat is pending. A saturating
//   counter records how many conflicting pairs were accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   x_valid / x_ready        input pair handshake (x_ready is combinational)
//   x_0, x_1                 lane samples
//   x_label_0, x_label_1     lane antenna/SFU labels
//   x_same_sfu               pair conflicts; sampled only on acceptance
//   y_0, y_1                 registered lane output samples
//   y_label_0, y_label_1     registered lane output labels
//   y_valid_0, y_valid_1     per-lane output valid
//   y_ready                  downstream takes the whole output beat
//   conflict_cnt             saturating count of accepted conflicting pairs
//   stat_clr                 synchronous clear of conflict_cnt
// ---------------------------------------------------------------------------
module sfu_conflict_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [DATA_WIDTH-1:0]  x_0,
    input  logic [DATA_WIDTH-1:0]  x_1,
    input  logic [LABEL_WIDTH-1:0] x_label_0,
    input  logic [LABEL_WIDTH-1:0] x_label_1,
    input  logic                   x_same_sfu,
    output logic [DATA_WIDTH-1:0]  y_0,
    output logic [DATA_WIDTH-1:0]  y_1,
    output logic [LABEL_WIDTH-1:0] y_label_0,
    output logic [LABEL_WIDTH-1:0] y_label_1,
    output logic                   y_valid_0,
    output logic                   y_valid_1,
    input  logic                   y_ready,
    output logic [CNT_WIDTH-1:0]   conflict_cnt,
    input  logic                   stat_clr
);

    typedef enum logic {
        S_PASS = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_hold_data;
    logic [LABEL_WIDTH-1:0] r_hold_label;

    logic w_out_busy;
    logic w_slot_free;
    logic w_accept;
    logic w_conflict;

    assign w_out_busy  = y_valid_0 | y_valid_1;
    // The output register can take a new beat if empty or being drained now.
    assign w_slot_free = !w_out_busy | y_ready;
    // Gated by rst so nothing is handshaken during a reset cycle.
    assign x_ready     = !rst && (r_state == S_PASS) && w_slot_free;
    assign w_accept    = x_valid & x_ready;
    assign w_conflict  = w_accept & x_same_sfu;

    // Output beat register and split FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_PASS;
            r_hold_data  <= '0;
            r_hold_label <= '0;
            y_0          <= '0;
            y_1          <= '0;
            y_label_0    <= '0;
            y_label_1    <= '0;
            y_valid_0    <= 1'b0;
            y_valid_1    <= 1'b0;
        end else begin
            case (r_state)
                S_PASS: begin
                    if (w_accept) begin
                        y_0       <= x_0;
                        y_label_0 <= x_label_0;
                        y_valid_0 <= 1'b1;
                        if (x_same_sfu) begin
                            // Lane 1 waits one beat so its SFU is not hit twice.
                            r_hold_data  <= x_1;
                            r_hold_label <= x_label_1;
                            y_valid_1    <= 1'b0;
                            r_state      <= S_HOLD;
                        end else begin
                            y_1       <= x_1;
                            y_label_1 <= x_label_1;
                            y_valid_1 <= 1'b1;
                        end
                    end else if (w_out_busy && y_ready) begin
                        // Beat consumed, nothing new: drop valids, keep data.
                        y_valid_0 <= 1'b0;
                        y_valid_1 <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_slot_free) begin
                        y_1       <= r_hold_data;
                        y_label_1 <= r_hold_label;
                        y_valid_0 <= 1'b0;
                        y_valid_1 <= 1'b1;
                        r_state   <= S_PASS;
                    end
                end
                default: r_state <= S_PASS;
            endcase
        end
    end

    // Conflict statistics; a same-cycle conflict wins over stat_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (w_conflict) begin
            if (stat_clr) begin
                conflict_cnt <= CNT_WIDTH'(1);
            end else if (conflict_cnt != {CNT_WIDTH{1'b1}}) begin
                conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
            end
        end else if (stat_clr) begin
            conflict_cnt <= '0;
        end
    end

endmodule

// File: doc/sfu_conflict_serializer.md
Name: sfu_conflict_serializer

Overview:
- Sits directly downstream of sfu_check and consumes its y_0/y_1/flag_same_sfu/y_valid pair together with the two antenna labels.
- Non-conflicting pairs are issued to the two SFU lanes in the same beat.
- Pairs flagged as targeting the same SFU are split into two consecutive beats, with upstream backpressure, so no SFU receives two samples in one cycle.
- Keeps a saturating conflict counter for performance monitoring.

Parameters:
- DATA_WIDTH, 8, sample width.
- LABEL_WIDTH, 4, antenna/SFU label width (16 antennas).
- CNT_WIDTH, 16, width of conflict statistics counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- x_valid  input  1  input pair valid (from sfu_check y_valid).
- x_ready  output  1  block can accept a pair this cycle.
- x_0  input  DATA_WIDTH  lane-0 sample.
- x_1  input  DATA_WIDTH  lane-1 sample.
- x_label_0  input  LABEL_WIDTH  lane-0 label.
- x_label_1  input  LABEL_WIDTH  lane-1 label.
- x_same_sfu  input  1  pair targets the same SFU (from flag_same_sfu).
- y_0  output  DATA_WIDTH  lane-0 output sample.
- y_1  output  DATA_WIDTH  lane-1 output sample.
- y_label_0  output  LABEL_WIDTH  lane-0 output label.
- y_label_1  output  LABEL_WIDTH  lane-1 output label.
- y_valid_0  output  1  lane-0 output valid.
- y_valid_1  output  1  lane-1 output valid.
- y_ready  input  1  downstream accepts the current output beat (both lanes together).
- conflict_cnt  output  CNT_WIDTH  number of accepted conflicting pairs, saturating.
- stat_clr  input  1  synchronous clear of conflict_cnt.

Behaviour:
- Reset: all y_* outputs are 0; y_valid_0 = y_valid_1 = 0; conflict_cnt = 0; hold register is cleared; state = PASS. x_ready is 0 during the rst cycle.
- Definitions:
  - out_busy = y_valid_0 | y_valid_1.
  - Output transfer = out_busy & y_ready.
  - slot_free = !out_busy | y_ready.
- Input acceptance: x_ready = (state == PASS) & slot_free, combinational, no dependence on x_valid. A pair is accepted when x_valid & x_ready.
- Output registers:
  - All y_* signals are registered; latency from acceptance to output is 1 cycle.
  - On a transfer with no new load, y_valid_0 and y_valid_1 clear to 0. Data and labels hold their previous values.
  - While out_busy & !y_ready, all y_* signals hold stable.
- State PASS, pair accepted with x_same_sfu = 0: load y_0/y_label_0 from lane 0 and y_1/y_label_1 from lane 1; y_valid_0 = y_valid_1 = 1. Stay in PASS.
- State PASS, pair accepted with x_same_sfu = 1:
  - Load lane 0 only: y_valid_0 = 1, y_valid_1 = 0.
  - Store x_1/x_label_1 in the hold register.
  - Go to HOLD.
  - conflict_cnt += 1, saturating at all-ones.
- State HOLD: x_ready = 0. When slot_free, load the held sample onto lane 1 (y_1/y_label_1, y_valid_1 = 1, y_valid_0 = 0) and return to PASS. The source lane is preserved.
- Throughput:
  - 1 pair/cycle when there are no conflicts and y_ready is held high.
  - A conflicting pair occupies 2 output beats and blocks input for exactly 1 cycle when y_ready = 1.
- The x_same_sfu flag is sampled only on acceptance; it is ignored when x_valid = 0.
- Labels are not compared here; the block trusts x_same_sfu.
- stat_clr:
  - stat_clr clears conflict_cnt to 0 the next cycle.
  - If a conflict is accepted in the same cycle as stat_clr, conflict_cnt becomes 1 (clear and increment, increment wins over zero).
- Reset mid-operation: a pending HOLD sample and any unaccepted output beat are discarded with no output. The block returns to PASS with outputs at reset values.
- y_ready low for N cycles: no data is lost or duplicated, and input stays stalled (x_ready = 0).

Test Plan:
- Reset: assert rst 2 cycles while x_valid = 1 → all outputs 0, x_ready = 0, conflict_cnt = 0. Deassert rst → x_ready = 1 next cycle.
- No conflict, streaming: y_ready = 1; pairs (0x11,0x22,lab 3,5), (0x33,0x44,lab 1,2), same = 0, on consecutive cycles → one cycle later, both lanes valid each cycle with the same values; x_ready stays 1.
- Conflict split: pair (0xA5,0x5A,lab 7,7), same = 1, y_ready = 1.
  - Cycle+1: y_0 = 0xA5, y_valid_0 = 1, y_valid_1 = 0, x_ready = 0.
  - Cycle+2: y_1 = 0x5A, y_label_1 = 7, y_valid_1 = 1, y_valid_0 = 0.
  - Cycle+3: x_ready = 1; conflict_cnt = 1.
- Backpressure: y_ready = 0 for 4 cycles during a conflict beat → y_0 = 0xA5 held stable, x_ready = 0. Then y_ready = 1 → 0x5A appears on lane 1 the next cycle; no duplication.
- Reset mid-HOLD: accept a conflicting pair, then assert rst in the following cycle → held 0x5A is never output, y_valid_* = 0, conflict_cnt = 0.
- Counter: CNT_WIDTH = 2, 5 conflicting pairs → conflict_cnt saturates at 3. Then stat_clr together with a conflict acceptance → conflict_cnt = 1.
